// File: rtl/dll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dll_pkg
// Description : Data link layer shared definitions: LCRC constants, the TX
//               framer state type, sequence/beat-length constants and the
//               bit-serial MSB-first LCRC update function that the TX framer
//               and the RX checker share.
// Revision    : 1.0  initial release
// ============================================================================
package dll_pkg;

    localparam logic [31:0] LCRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] LCRC_INIT = 32'hFFFFFFFF;

    localparam int          SEQ_W    = 12;
    localparam logic [5:0]  LEN_FULL = 6'd16;
    localparam logic [5:0]  LEN_LAST = 6'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_LAST  = 2'd3
    } lcrc_tx_state_t;

    // Shifts data[nbits-1] down to data[0] through the CRC, MSB first.
    // The loop bound is fixed so the function unrolls to a static network.
    function automatic logic [31:0] lcrc_update(
        input logic [31:0]  crc,
        input logic [127:0] data,
        input int           nbits,
        input logic [31:0]  poly = LCRC_POLY
    );
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 127; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[31] ^ data[i];
                c  = {c[30:0], 1'b0};
                if (fb) begin
                    c = c ^ poly;
                end
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcrc32_step.sv
`default_nettype none
// ============================================================================
// Module      : lcrc32_step
// Description : Combinational LCRC advance over either a 128-bit chunk or a
//               16-bit chunk, chosen by sel16.
// Ports       : crc_in    current remainder
//               chunk128  128-bit data chunk (used when sel16 = 0)
//               chunk16   16-bit data chunk  (used when sel16 = 1)
//               sel16     chunk select
//               crc_out   advanced remainder
// Revision    : 1.0  initial release
// ============================================================================
module lcrc32_step
    import dll_pkg::*;
#(
    parameter logic [31:0] POLY = 32'h04C11DB7
) (
    input  logic [31:0]  crc_in,
    input  logic [127:0] chunk128,
    input  logic [15:0]  chunk16,
    input  logic         sel16,
    output logic [31:0]  crc_out
);

    always_comb begin
        crc_out = crc_in;
        if (sel16) begin
            crc_out = lcrc_update(crc_in, {112'b0, chunk16}, 16, POLY);
        end else begin
            crc_out = lcrc_update(crc_in, chunk128, 128, POLY);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcrc_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcrc_gen
// Description : Data link layer TX framer. Accepts one 128/256-bit TLP,
//               prepends {4'b0, seq}, and emits 128-bit beats ending with a
//               beat carrying the last 16 frame bits and the 32-bit LCRC.
// Ports       : clk, rst (async, active-low)
//               tlp_vld/tlp_rdy/tlp_data/tlp_long   TLP input handshake
//               tx_vld/tx_rdy/tx_data/tx_len/tx_end beat output handshake
//               tlp_seq    sequence number of the held/sent frame
//               tlp_taken  one-cycle pulse after each accepted TLP
// Revision    : 1.0  initial release
// ============================================================================
module lcrc_gen
    import dll_pkg::*;
#(
    parameter logic [31:0] POLY     = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tlp_vld,
    output logic              tlp_rdy,
    input  logic [255:0]      tlp_data,
    input  logic              tlp_long,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic [127:0]      tx_data,
    output logic [5:0]        tx_len,
    output logic              tx_end,
    output logic [SEQ_W-1:0]  tlp_seq,
    output logic              tlp_taken
);

    lcrc_tx_state_t   state;
    lcrc_tx_state_t   next_state;

    // The first beat is {4'b0, seq, tlp[255:144]} for both TLP sizes; only
    // the second chunk and the 16-bit tail differ between short and long.
    logic [127:0]     chunk0;
    logic [127:0]     chunk1;
    logic [15:0]      tail;
    logic             is_long;
    logic [31:0]      acc;
    logic [SEQ_W-1:0] next_seq;

    logic             accept;
    logic             beat_hs;
    logic [127:0]     cur_chunk;
    logic [31:0]      acc_next;
    logic [31:0]      lcrc;

    assign tlp_rdy   = (state == ST_IDLE);
    assign accept    = tlp_rdy && tlp_vld;
    assign beat_hs   = tx_vld && tx_rdy;
    assign cur_chunk = (state == ST_BEAT1) ? chunk1 : chunk0;

    lcrc32_step #(.POLY(POLY)) u_acc_step (
        .crc_in   (acc),
        .chunk128 (cur_chunk),
        .chunk16  (16'h0000),
        .sel16    (1'b0),
        .crc_out  (acc_next)
    );

    lcrc32_step #(.POLY(POLY)) u_last_step (
        .crc_in   (acc),
        .chunk128 (128'h0),
        .chunk16  (tail),
        .sel16    (1'b1),
        .crc_out  (lcrc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            chunk0    <= '0;
            chunk1    <= '0;
            tail      <= '0;
            is_long   <= 1'b0;
            acc       <= CRC_INIT;
            next_seq  <= '0;
            tlp_seq   <= '0;
            tlp_taken <= 1'b0;
        end else begin
            state     <= next_state;
            tlp_taken <= accept;
            if (accept) begin
                chunk0   <= {4'b0000, next_seq, tlp_data[255:144]};
                chunk1   <= tlp_data[143:16];
                tail     <= tlp_long ? tlp_data[15:0] : tlp_data[143:128];
                is_long  <= tlp_long;
                acc      <= CRC_INIT;
                tlp_seq  <= next_seq;
                next_seq <= next_seq + 1'b1;
            end else if (beat_hs && (state != ST_LAST)) begin
                // The last beat's LCRC is formed combinationally from acc,
                // so acc only advances on the full 128-bit beats.
                acc <= acc_next;
            end
        end
    end

    always_comb begin
        next_state = state;
        tx_vld     = 1'b0;
        tx_data    = '0;
        tx_len     = '0;
        tx_end     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tlp_vld) begin
                    next_state = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                tx_vld  = 1'b1;
                tx_data = chunk0;
                tx_len  = LEN_FULL;
                if (tx_rdy) begin
                    next_state = is_long ? ST_BEAT1 : ST_LAST;
                end
            end
            ST_BEAT1: begin
                tx_vld  = 1'b1;
                tx_data = chunk1;
                tx_len  = LEN_FULL;
                if (tx_rdy) begin
                    next_state = ST_LAST;
                end
            end
            ST_LAST: begin
                tx_vld  = 1'b1;
                tx_data = {tail, lcrc, 80'b0};
                tx_len  = LEN_LAST;
                tx_end  = 1'b1;
                if (tx_rdy) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/lcrc_gen.md
# lcrc_gen

Data link layer TX framer, the transmit counterpart of the RX LCRC checker. It accepts one TLP of 128 or 256 bits from the transaction layer and prepends the 16-bit sequence field. It computes the 32-bit LCRC over the sequence field plus the TLP and emits the frame as 128-bit beats toward the TX physical mux. The beat layout is exactly the one the RX checker consumes.

## Interface
- POLY, 32'h04C11DB7, CRC polynomial.
- CRC_INIT, 32'hFFFFFFFF, CRC seed loaded for every frame.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tlp_vld  in  1  TLP offered by the transaction layer.
- tlp_rdy  out  1  block can accept a TLP.
- tlp_data  in  256  TLP, MSB first; short TLPs occupy [255:128].
- tlp_long  in  1  0 = 128-bit TLP, 1 = 256-bit TLP.
- tx_vld  out  1  output beat valid.
- tx_rdy  in  1  downstream accepts the beat.
- tx_data  out  128  output beat.
- tx_len  out  6  valid bytes in the beat: 16 for full beats, 6 for the last beat.
- tx_end  out  1  last beat of the frame.
- tlp_seq  out  12  sequence number of the frame currently held or being sent (for the retry buffer).
- tlp_taken  out  1  one-cycle pulse on each accepted TLP.

## Operation
- Frame construction:
  - Frame F = {4'b0000, seq[11:0], TLP}.
  - F is 144 bits for a short TLP and 272 bits for a long TLP.
- Sequence counter `next_seq`:
  - 12 bits, reset 0.
  - Captured into `tlp_seq` on accept, then incremented modulo 4096 (4095 wraps to 0).
- CRC rules:
  - MSB-first serial CRC over all bits of F, F[msb] first.
  - Seed CRC_INIT, polynomial POLY.
  - No bit reflection, no final inversion.
  - LCRC is the 32-bit remainder.
- Beat layout, short frame (2 beats):
  - Beat 0 = F[143:16].
  - Beat 1 = {F[15:0], LCRC, 80'b0}, with `tx_end` = 1.
- Beat layout, long frame (3 beats):
  - Beat 0 = F[271:144].
  - Beat 1 = F[143:16].
  - Beat 2 = {F[15:0], LCRC, 80'b0}, with `tx_end` = 1.
- Internal storage:
  - A CRC accumulator register is seeded with CRC_INIT on accept.
  - It is updated with each 128-bit chunk when that beat handshakes (`tx_vld && tx_rdy`).
  - On the last beat, the output LCRC = update(acc, F[15:0]) computed combinationally; the accumulator itself is not written.
- FSM states and transitions:
  - IDLE: `tlp_rdy` = 1. On `tlp_vld`, capture F, seed the accumulator, pulse `tlp_taken`, go to BEAT0.
  - BEAT0: drives beat 0. On handshake: short → LAST, long → BEAT1.
  - BEAT1: drives beat 1 (long frames only). On handshake → LAST.
  - LAST: drives the LCRC beat. On handshake → IDLE.
- Backpressure:
  - `tx_rdy` = 0 holds the state; `tx_data`, `tx_len` and `tx_end` stay stable.
  - The accumulator is not updated while held.
  - `tx_vld` never drops before its handshake.
- Input stability: `tlp_data` and `tlp_long` are sampled only at accept; later changes have no effect.

## Timing
- Reset values:
  - `tlp_rdy` = 1 (IDLE).
  - `tx_vld`, `tx_end`, `tlp_taken` = 0.
  - `tx_data` = 0, `tx_len` = 0, `tlp_seq` = 0.
  - `next_seq` = 0, accumulator = CRC_INIT.
- Latency: beat 0 is valid in the cycle after the accept edge.
- Throughput with `tx_rdy` held at 1:
  - Short frame: 2 beat cycles plus 1 IDLE cycle, so 3 cycles per TLP.
  - Long frame: 4 cycles per TLP.
- `tlp_rdy` depends on state only; there is no combinational path from `tx_rdy`.
- `tx_len` = 16 on non-last beats and 6 on the last beat; `tx_end` = 1 only on the last beat.
- Reset mid-frame:
  - Immediate return to IDLE; `tx_vld` drops asynchronously.
  - `next_seq` returns to 0 and the partial frame is discarded.
- `tlp_vld` during BEAT0/BEAT1/LAST is ignored because `tlp_rdy` = 0.

## Structure
- Shared package `dll_pkg` holds:
  - constants LCRC_POLY and LCRC_INIT;
  - the FSM enum type `lcrc_tx_state_t`;
  - SEQ_W = 12 and beat-length constants (16, 6);
  - a function `lcrc_update(crc, data, nbits)` that is bit-serial and MSB-first, shared with the RX checker.
- One sub-module `lcrc32_step`:
  - combinational;
  - takes a 128-bit chunk and a 16-bit chunk, with a select;
  - instantiated for the accumulator update and the last-beat LCRC.

## Test plan
- **Reset values:** reset, then release → `tlp_rdy` = 1, `tx_vld` = 0, `tlp_seq` = 0.
- **Short all-zero TLP:** short TLP of all zeros with `tx_rdy` = 1.
  - Beat 0 = 128'h0 with `tx_len` = 16.
  - Beat 1[127:112] = 16'h0000, [111:80] = golden serial-model LCRC, [79:0] = 0, `tx_end` = 1, `tx_len` = 6.
  - Looped into the RX checker, it flags the frame valid.
- **Long TLP 256'h0123…CDEF, seq 5:**
  - Beat 0[127:112] = 16'h0005.
  - Three beats; `tx_end` only on beat 2.
  - LCRC matches the golden model over the 272 bits.
- **Backpressure:** `tx_rdy` = 0 for 4 cycles in BEAT1 → beat held stable, and the final LCRC is identical to the no-stall run.
- **Sequence wrap:** 4097 back-to-back TLPs → `tlp_seq` runs 0…4095, then 0; `tlp_taken` pulses 4097 times.
- **Reset mid-frame:** reset asserted during LAST → `tx_vld` = 0 immediately; the next TLP is sent with seq 0 and a correct LCRC.
